// File: rtl/real_table_seq.sv
// real_table_seq: writable table of DEPTH signed fixed-point samples
// (WIDTH bits, exponent EXPONENT). A programmable address window is played
// out through a valid/ready stream in one-shot, loop or ping-pong mode.
// Optional build macro REAL_TABLE_SEQ_GAIN_EN adds a signed gain port that
// scales each sample with saturation as it is loaded.
module real_table_seq #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int WIDTH    = 16,
    parameter int EXPONENT = -8,
    parameter int GAIN_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] lo_addr,
    input  logic [ADDR_W-1:0] hi_addr,
`ifdef REAL_TABLE_SEQ_GAIN_EN
    input  logic [GAIN_W-1:0] gain,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // state | meaning
    // IDLE  | waiting for an accepted start; output register not valid
    // RUN   | streaming the latched window; out_valid high
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] M_ONE  = 2'b00;
    localparam logic [1:0] M_LOOP = 2'b01;
    localparam logic [1:0] M_PING = 2'b10;
    localparam logic [1:0] M_RSV  = 2'b11;

    // EXPONENT is format metadata only; it is referenced here so it stays
    // part of the elaborated parameter set. Legal settings give an empty block.
    if (DEPTH < 2 || (1 << ADDR_W) != DEPTH || GAIN_W < 2 || EXPONENT < -1024) begin : g_param_guard
    end

    logic [WIDTH-1:0]  tbl_q [DEPTH];
    state_t            state_q, state_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic [ADDR_W-1:0] lo_q, lo_nxt, hi_q, hi_nxt;
    logic [ADDR_W-1:0] addr_q, load_addr, step_addr;
    logic [WIDTH-1:0]  data_q, load_data;
    logic              dir_up_q, dir_nxt, step_dir;
    logic              valid_q, valid_nxt, done_q, done_nxt, err_q, err_nxt;
    logic              load;

    // Table storage; reads elsewhere see the pre-edge contents, so a load
    // coinciding with a write to the same address takes the old sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else if (wr_en) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    // Successor address inside the window; never leaves [lo, hi] except the
    // one-shot increment past hi, which is never loaded.
    always_comb begin
        step_addr = addr_q + ADDR_W'(1);
        step_dir  = dir_up_q;
        case (mode_q)
            M_LOOP: if (addr_q == hi_q) step_addr = lo_q;
            M_PING: begin
                if (dir_up_q) begin
                    if (addr_q == hi_q) begin
                        if (addr_q == lo_q) begin
                            step_addr = addr_q;
                        end else begin
                            step_addr = addr_q - ADDR_W'(1);
                            step_dir  = 1'b0;
                        end
                    end
                end else begin
                    if (addr_q == lo_q) begin
                        step_dir = 1'b1;
                    end else begin
                        step_addr = addr_q - ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Next-state and load control; stop outranks a simultaneous transfer.
    always_comb begin
        state_nxt = state_q;
        mode_nxt  = mode_q;
        lo_nxt    = lo_q;
        hi_nxt    = hi_q;
        load      = 1'b0;
        load_addr = addr_q;
        dir_nxt   = dir_up_q;
        valid_nxt = valid_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode == M_RSV || lo_addr > hi_addr) begin
                        err_nxt = 1'b1;
                    end else begin
                        state_nxt = RUN;
                        mode_nxt  = mode;
                        lo_nxt    = lo_addr;
                        hi_nxt    = hi_addr;
                        load      = 1'b1;
                        load_addr = lo_addr;
                        dir_nxt   = 1'b1;
                        valid_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end else if (valid_q && out_ready) begin
                    if (mode_q == M_ONE && addr_q == hi_q) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        load      = 1'b1;
                        load_addr = step_addr;
                        dir_nxt   = step_dir;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef REAL_TABLE_SEQ_GAIN_EN
    localparam int PW = WIDTH + GAIN_W;
    localparam logic signed [PW-1:0] SAT_MAX = {{(GAIN_W+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(GAIN_W+1){1'b1}}, {(WIDTH-1){1'b0}}};
    logic signed [PW-1:0] prod, scaled;

    // Scale the fetched sample by gain (1.0 = 1<<(GAIN_W-2)) and clamp.
    always_comb begin
        prod   = PW'($signed(tbl_q[load_addr])) * PW'($signed(gain));
        scaled = prod >>> (GAIN_W - 2);
        if (scaled > SAT_MAX)      load_data = SAT_MAX[WIDTH-1:0];
        else if (scaled < SAT_MIN) load_data = SAT_MIN[WIDTH-1:0];
        else                       load_data = scaled[WIDTH-1:0];
    end
`else
    assign load_data = tbl_q[load_addr];
`endif

    // State and output registers; the output sample changes only on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= M_ONE;
            lo_q     <= '0;
            hi_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            dir_up_q <= 1'b1;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            mode_q  <= mode_nxt;
            lo_q    <= lo_nxt;
            hi_q    <= hi_nxt;
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            if (load) begin
                addr_q   <= load_addr;
                data_q   <= load_data;
                dir_up_q <= dir_nxt;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_real_table_seq.sv
// Self-checking bench for real_table_seq: a scoreboard of expected
// (address, sample) pairs is filled when a sequence is launched and drained
// by a monitor on every observed transfer. Build with REAL_TABLE_SEQ_GAIN_EN
// to also exercise the gain path.
module tb_real_table_seq;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int W     = 16;
    localparam int GW    = 16;

    logic          clk = 1'b0;
    logic          rst, wr_en, start, stop, out_ready;
    logic [AW-1:0] wr_addr, lo_addr, hi_addr, out_addr;
    logic [W-1:0]  wr_data, out_data;
    logic [1:0]    mode;
    logic          out_valid, busy, done, err;
`ifdef REAL_TABLE_SEQ_GAIN_EN
    logic [GW-1:0] gain;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int tbl [DEPTH];
    int qa [$];
    int qd [$];

    real_table_seq #(.DEPTH(DEPTH), .ADDR_W(AW), .WIDTH(W), .EXPONENT(-8), .GAIN_W(GW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .mode(mode), .lo_addr(lo_addr), .hi_addr(hi_addr),
`ifdef REAL_TABLE_SEQ_GAIN_EN
        .gain(gain),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_out(input int s);
`ifdef REAL_TABLE_SEQ_GAIN_EN
        longint p;
        p = longint'(s) * longint'($signed(gain));
        p = p >>> (GW - 2);
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
`else
        return s;
`endif
    endfunction

    function automatic int model_addr(input int m, input int l, input int h, input int k);
        int len, per, pos;
        len = h - l + 1;
        case (m)
            0: return l + k;
            1: return l + (k % len);
            default: begin
                if (len == 1) return l;
                per = 2 * (len - 1);
                pos = k % per;
                return (pos < len) ? l + pos : h - (pos - (len - 1));
            end
        endcase
    endfunction

    task automatic push_exp(input int m, input int l, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            int a;
            a = model_addr(m, l, h, k);
            qa.push_back(a);
            qd.push_back(model_out(tbl[a]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input int a, input int v);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = W'(v);
        cyc();
        wr_en = 1'b0;
        tbl[a] = v;
    endtask

    task automatic drain_chk(input string tag);
        chk_val(tag, qa.size(), 0);
        qa.delete();
        qd.delete();
    endtask

    // Monitor: every transfer must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (qa.size() == 0) begin
                    chk_val("sb_underflow", qa.size(), 1);
                end else begin
                    chk_val("xfer_addr", int'(out_addr), qa.pop_front());
                    chk_val("xfer_data", int'($signed(out_data)), qd.pop_front());
                end
            end
        end
    end

    task automatic run_oneshot(input int l, input int h);
        int len;
        len = h - l + 1;
        push_exp(0, l, h, len);
        mode = 2'b00; lo_addr = AW'(l); hi_addr = AW'(h); out_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            chk_val("os_done", int'(done), int'(c == len));
            chk_val("os_busy", int'(busy), int'(c < len));
            cyc();
        end
        @(negedge clk);
        chk_val("os_done_clear", int'(done), 0);
        chk_val("os_valid_idle", int'(out_valid), 0);
        drain_chk("os_drain");
    endtask

    task automatic run_stream(input int m, input int l, input int h, input int n, input bit tog);
        int cnt, cycles;
        push_exp(m, l, h, n);
        mode = 2'(m); lo_addr = AW'(l); hi_addr = AW'(h); out_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cnt = 0; cycles = 0;
        while (cnt < n && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (out_valid && out_ready) cnt++;
            if (cnt < n) begin
                cyc();
                if (tog) out_ready = ~out_ready;
            end
        end
        if (cnt < n) chk_val("stream_timeout", cnt, n);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk_val("stop_valid", int'(out_valid), 0);
        chk_val("stop_busy", int'(busy), 0);
        chk_val("stop_no_done", int'(done), 0);
        drain_chk("stream_drain");
    endtask

    task automatic run_reject(input int m, input int l, input int h);
        mode = 2'(m); lo_addr = AW'(l); hi_addr = AW'(h); start = 1'b1;
        cyc();
        start = 1'b0;
        @(negedge clk);
        chk_val("rej_err", int'(err), 1);
        chk_val("rej_valid", int'(out_valid), 0);
        chk_val("rej_busy", int'(busy), 0);
        cyc();
        @(negedge clk);
        chk_val("rej_err_clear", int'(err), 0);
        chk_val("rej_valid_after", int'(out_valid), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; stop = 1'b0;
        mode = 2'b00; lo_addr = '0; hi_addr = '0; out_ready = 1'b1;
`ifdef REAL_TABLE_SEQ_GAIN_EN
        gain = 16'h4000;
`endif
        for (int i = 0; i < DEPTH; i++) tbl[i] = 0;
        repeat (3) cyc();
        @(negedge clk);
        chk_val("rst_valid", int'(out_valid), 0);
        chk_val("rst_data", int'(out_data), 0);
        chk_val("rst_addr", int'(out_addr), 0);
        chk_val("rst_busy", int'(busy), 0);
        chk_val("rst_done", int'(done), 0);
        chk_val("rst_err", int'(err), 0);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < DEPTH; i++) write_tbl(i, 100 * i);

        run_oneshot(2, 4);
        run_stream(1, 0, 3, 10, 1'b1);
        run_stream(2, 5, 7, 10, 1'b0);
        run_reject(0, 6, 2);
        run_reject(3, 1, 2);

        // Loop on a single entry with a write landing on a load edge.
        for (int k = 0; k < 3; k++) begin qa.push_back(3); qd.push_back(model_out(300)); end
        for (int k = 0; k < 2; k++) begin qa.push_back(3); qd.push_back(model_out(-50)); end
        mode = 2'b01; lo_addr = 3'd3; hi_addr = 3'd3; out_ready = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = W'(-50);
        cyc();
        wr_en = 1'b0;
        tbl[3] = -50;
        cyc();
        cyc();
        @(negedge clk);
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk_val("midrst_valid", int'(out_valid), 0);
        chk_val("midrst_data", int'(out_data), 0);
        chk_val("midrst_addr", int'(out_addr), 0);
        chk_val("midrst_busy", int'(busy), 0);
        chk_val("midrst_done", int'(done), 0);
        drain_chk("midrst_drain");
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) tbl[i] = 0;
        cyc();
        run_oneshot(1, 4);

`ifdef REAL_TABLE_SEQ_GAIN_EN
        write_tbl(0, 20000);
        gain = 16'h8000;
        run_oneshot(0, 0);
        gain = 16'h2000;
        run_oneshot(0, 0);
        gain = 16'h4000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/real_table_seq.md
Name: real_table_seq

Overview:
- Parametrised successor to the fixed 4-entry real-valued array block.
- Holds a writable table of DEPTH signed fixed-point samples in the codebase real format, WIDTH bits with exponent EXPONENT.
- Plays a programmable address window out through a valid/ready stream in one-shot, loop or ping-pong mode.
- Used in analog-model testbenches and emulators as a stimulus/waveform source that replaces a free-running address counter.

Parameters:
- DEPTH, 8, number of table entries (power of two, >=2)
- ADDR_W, $clog2(DEPTH), address width
- WIDTH, 16, sample width, signed two's complement
- EXPONENT, -8, fixed-point exponent of samples (metadata only, passed through to the real-type macros)
- GAIN_W, 16, gain width (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write sample
- start  in  1  launch sequence (sampled only in IDLE)
- stop  in  1  abort sequence
- mode  in  2  00 one-shot, 01 loop, 10 ping-pong, 11 reserved
- lo_addr  in  ADDR_W  window start
- hi_addr  in  ADDR_W  window end
- out_valid  out  1  sample valid
- out_ready  in  1  consumer ready
- out_data  out  WIDTH  sample
- out_addr  out  ADDR_W  table address of out_data
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of one-shot
- err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: all table entries = 0; out_valid=0, out_data=0, out_addr=0, busy=0, done=0, err=0; state IDLE. Reset mid-run aborts immediately, with no done pulse.
- States: IDLE, RUN.
- IDLE -> RUN on start=1 when mode!=11 and lo_addr<=hi_addr. mode, lo and hi are latched at that edge.
- Rejected start (mode=11 or lo>hi): err=1 for one cycle, remain IDLE.
- Output timing: first sample (address lo) is registered on the start edge, so out_valid=1 and busy=1 the cycle after start.
- Transfer: a transfer occurs when out_valid&&out_ready. The next sample loads on that edge with no bubble. out_data and out_addr hold stable while out_valid&&!out_ready.
- Address sequence, lo=1, hi=3:
  - one-shot: 1,2,3. On transfer of hi: done=1 for that next cycle, out_valid=0, busy=0, back to IDLE.
  - loop: 1,2,3,1,2,3,... (wrap hi->lo).
  - ping-pong: 1,2,3,2,1,2,3,... Endpoints are emitted once per turn.
  - lo==hi: one-shot emits one sample; loop and ping-pong repeat that sample.
- stop=1 in RUN: next cycle out_valid=0, busy=0, IDLE, no done. stop has priority over a simultaneous transfer. stop in IDLE is ignored. start in RUN is ignored.
- Table writes:
  - Allowed in any state; visible to any load on the following edge or later.
  - A write on the same edge as a load of that address: old data is loaded.
  - A sample already held in the output register is never modified by writes.
- DEPTH wrap: ADDR_W arithmetic never exceeds hi, so no modulo wrap beyond the window occurs.

Optional Feature:
- Macro: REAL_TABLE_SEQ_GAIN_EN.
- Defined:
  - Adds input port gain (GAIN_W, signed, Q format with 1.0 = 1<<(GAIN_W-2)).
  - gain is sampled on each load edge.
  - out_data = saturate_WIDTH((sample*gain) >>> (GAIN_W-2)), arithmetic shift, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Latency is unchanged.
- Undefined: gain port absent; out_data = table sample unchanged.

Test Plan:
- Reset, then write table[i]=100*i for i=0..7; start one-shot, lo=2, hi=4, out_ready=1 -> out_data 200,300,400 on consecutive cycles starting the cycle after start; done pulses the cycle after 400 transfers; busy=0 afterwards.
- Loop mode, lo=0, hi=3, out_ready toggling 1,0 -> addresses 0,1,2,3,0,1..., each held stable during ready=0, no address skipped or duplicated.
- Ping-pong, lo=5, hi=7, 10 transfers -> addresses 5,6,7,6,5,6,7,6,5,6; stop after the 10th -> out_valid=0 next cycle, no done.
- start with lo=6, hi=2 -> err=1 for one cycle, out_valid stays 0; mode=11 -> same result.
- Loop on lo=hi=3 while writing table[3]=-50 mid-run -> old value on the write edge's load, -50 on all later samples; assert rst mid-run -> all outputs 0 the next cycle and table reads 0.
- With REAL_TABLE_SEQ_GAIN_EN, GAIN_W=16, gain=0x8000 (-2.0), table[0]=20000 -> out_data=-32768 (saturated); gain=0x2000 (0.5) -> 10000.
